// File: rtl/layer_output_sequencer_if.sv
// Bundles the layer-to-layer hand-off: parallel neuron results in, serial stream and status out.
// Latency: none, wiring only.
// Backpressure: out_stall travels from the stream consumer back to the sequencer.
interface layer_output_sequencer_if #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
);
    localparam int IW = $clog2(NN);

    logic [NN-1:0]           o_valid;
    logic [NN*dataWidth-1:0] x_out;
    logic                    out_stall;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_in;
    logic                    layer_done;
    logic                    overrun;
    logic [IW-1:0]           max_idx;

    // master: the environment (source layer, downstream stall, status observer)
    modport master (
        output o_valid, x_out, out_stall,
        input  x_valid, x_in, layer_done, overrun, max_idx
    );

    // slave: the sequencer itself
    modport slave (
        input  o_valid, x_out, out_stall,
        output x_valid, x_in, layer_done, overrun, max_idx
    );
endinterface

// File: rtl/layer_output_sequencer.sv
// Collects NN parallel neuron results, replays them as a serial (x_in, x_valid) stream; optional argmax (MAXFIND_EN).
// Latency: first beat in the cycle after the last result bit arrives; layer_done the cycle after the last beat.
// Backpressure: out_stall freezes the stream (x_valid low, index and data held); no beat is lost or repeated.
module layer_output_sequencer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input logic                     clk,
    input logic                     rst,
    layer_output_sequencer_if.slave bus
);
    localparam int            IW       = $clog2(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic {
        ST_COLLECT,
        ST_SEND
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [dataWidth-1:0] data_q [NN];
    logic [NN-1:0]        mask_q;
    logic [NN-1:0]        mask_all;
    logic [IW-1:0]        idx_q;
    logic                 layer_done_q;
    logic                 overrun_q;
    logic                 frame_full;
    logic                 beat_vld;
    logic                 last_beat;
    logic [dataWidth-1:0] cur_dat;

    // A frame is complete once every slot is either already pending or arriving now.
    assign mask_all   = mask_q | bus.o_valid;
    assign frame_full = &mask_all;
    assign beat_vld   = (state_q == ST_SEND) && !bus.out_stall;
    assign last_beat  = beat_vld && (idx_q == LAST_IDX);
    assign cur_dat    = data_q[idx_q];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_COLLECT;
        else      state_q <= state_d;
    end

    // Next state: collect until every slot is filled, send until the last beat leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_COLLECT: if (frame_full) state_d = ST_SEND;
            ST_SEND:    if (last_beat)  state_d = ST_COLLECT;
            default:    state_d = ST_COLLECT;
        endcase
    end

    // Capture results while collecting; a repeat pulse on a filled slot overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NN; i++) data_q[i] <= '0;
            mask_q <= '0;
        end else if (state_q == ST_COLLECT) begin
            for (int i = 0; i < NN; i++) begin
                if (bus.o_valid[i]) data_q[i] <= bus.x_out[i*dataWidth +: dataWidth];
            end
            mask_q <= mask_all;
        end else if (last_beat) begin
            mask_q <= '0;
        end
    end

    // Stream index: parked at 0 while collecting, advances only on emitted beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
        end else if (state_q == ST_COLLECT || last_beat) begin
            idx_q <= '0;
        end else if (beat_vld) begin
            idx_q <= idx_q + IW'(1);
        end
    end

    // Frame-done pulse and sticky overrun (results arriving while the buffer is busy sending).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            layer_done_q <= last_beat;
            overrun_q    <= overrun_q | ((state_q == ST_SEND) && (|bus.o_valid));
        end
    end

    assign bus.x_valid    = beat_vld;
    assign bus.x_in       = (state_q == ST_SEND) ? cur_dat : '0;
    assign bus.layer_done = layer_done_q;
    assign bus.overrun    = overrun_q;

`ifdef MAXFIND_EN
    logic signed [dataWidth-1:0] run_max_q;
    logic [IW-1:0]               run_idx_q;
    logic [IW-1:0]               max_idx_q;
    logic                        take;

    // First beat always seeds the max; later beats replace it only when strictly greater.
    assign take = (idx_q == '0) || ($signed(cur_dat) > run_max_q);

    // Running signed max over emitted beats; result published with the layer_done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            max_idx_q <= '0;
        end else if (beat_vld) begin
            if (take) begin
                run_max_q <= $signed(cur_dat);
                run_idx_q <= idx_q;
            end
            if (last_beat) max_idx_q <= take ? idx_q : run_idx_q;
        end
    end

    assign bus.max_idx = max_idx_q;
`else
    assign bus.max_idx = '0;
`endif
endmodule

// File: tb/tb_layer_output_sequencer.sv
// Directed bench for layer_output_sequencer: frame capture, stream timing, stall, overrun, reset abort, argmax.
// Latency: checks first beat one cycle after the final result bit, layer_done one cycle after the last beat.
// Backpressure: drives out_stall mid-frame and checks hold-then-resume behaviour.
module tb_layer_output_sequencer;
    localparam int NN = 10;
    localparam int DW = 16;

    typedef logic [DW-1:0] frame_t [NN];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_output_sequencer_if #(.NN(NN), .dataWidth(DW)) bus ();

    layer_output_sequencer #(.NN(NN), .dataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            total    = 0;
    int            bad      = 0;
    int            done_cnt = 0;
    logic [DW-1:0] beats [$];

    // Stream monitor: record every valid beat and every layer_done pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.x_valid)    beats.push_back(bus.x_in);
            if (bus.layer_done) done_cnt++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input frame_t v, input logic [NN-1:0] m);
        bus.o_valid = m;
        for (int i = 0; i < NN; i++) bus.x_out[i*DW +: DW] = v[i];
    endtask

    function automatic logic [31:0] exp_max(input int v);
`ifdef MAXFIND_EN
        return 32'(v);
`else
        if (v < 0) return 32'd1;
        return 32'd0;
`endif
    endfunction

    // Called at edge+1 of the first stream cycle; returns at edge+2 of the layer_done cycle.
    task automatic expect_stream(input frame_t ev, input int stall_at, input int stall_len,
                                 input int inj_at, input logic [31:0] prev_max);
        beats.delete();
        for (int b = 0; b < NN; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.out_stall = 1'b1;
                    bus.o_valid   = '0;
                    #1;
                    chk("stall_vld", 32'(bus.x_valid), 32'd0);
                    chk("stall_hold", 32'(bus.x_in), 32'(ev[b]));
                    tick();
                end
            end
            bus.out_stall = 1'b0;
            if (b == inj_at) begin
                bus.o_valid = 10'h004;
                bus.x_out[2*DW +: DW] = 16'hDEAD;
            end else begin
                bus.o_valid = '0;
            end
            #1;
            chk("beat_vld", 32'(bus.x_valid), 32'd1);
            chk("beat_dat", 32'(bus.x_in), 32'(ev[b]));
            chk("beat_done", 32'(bus.layer_done), 32'd0);
            if (b == 0) chk("max_hold", 32'(bus.max_idx), prev_max);
            tick();
        end
        bus.o_valid = '0;
        #1;
        chk("done_pulse", 32'(bus.layer_done), 32'd1);
        chk("done_vld", 32'(bus.x_valid), 32'd0);
        chk("beat_cnt", 32'(beats.size()), 32'(NN));
        for (int i = 0; i < NN && i < beats.size(); i++) chk("mon_dat", 32'(beats[i]), 32'(ev[i]));
    endtask

    frame_t f1, f2, f3, f4, f6, f7;
    int     d0;

    initial begin
        for (int i = 0; i < NN; i++) begin
            f1[i] = DW'(i + 1);
            f2[i] = 16'h0100 + DW'(i);
            f3[i] = 16'h2000 + DW'(i);
            f4[i] = 16'h0300 + DW'(i * 17);
        end
        f6 = '{16'hFFFB, 16'd7, 16'd3, 16'd7, 16'd2, 16'd0, 16'hFFFD, 16'd6, 16'd1, 16'hFFFF};
        f7 = '{16'hFFF7, 16'hFFFC, 16'hFFF9, 16'hFFFE, 16'hFFF8,
               16'hFFFD, 16'hFFFE, 16'hFFFA, 16'hFFFB, 16'hFFF6};
        bus.o_valid   = '0;
        bus.x_out     = '0;
        bus.out_stall = 1'b0;

        // Reset state
        #1;
        chk("rst_vld", 32'(bus.x_valid), 32'd0);
        chk("rst_dat", 32'(bus.x_in), 32'd0);
        chk("rst_done", 32'(bus.layer_done), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        chk("rst_max", 32'(bus.max_idx), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: all results in one cycle, slot i = i+1
        drive(f1, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f1, -1, 0, -1, 32'd0);
        chk("t1_ovr", 32'(bus.overrun), 32'd0);
        chk("t1_max", 32'(bus.max_idx), exp_max(9));
        tick();
        chk("t1_done_off", 32'(bus.layer_done), 32'd0);

        // 2: split arrival, slot 0 overwritten before the frame completes
        drive(f2, 10'h01F);
        tick();
        f2[0] = 16'h0AAA;
        drive(f2, 10'h001);
        #1;
        chk("t2_wait1", 32'(bus.x_valid), 32'd0);
        tick();
        bus.o_valid = '0;
        #1;
        chk("t2_wait2", 32'(bus.x_valid), 32'd0);
        tick();
        drive(f2, 10'h3E0);
        #1;
        chk("t2_wait3", 32'(bus.x_valid), 32'd0);
        tick();
        bus.o_valid = '0;
        expect_stream(f2, -1, 0, -1, exp_max(9));
        chk("t2_max", 32'(bus.max_idx), exp_max(0));

        // 3: next frame presented in the layer_done cycle; 3-cycle stall at beat 4
        drive(f3, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f3, 4, 3, -1, exp_max(0));
        chk("t3_ovr", 32'(bus.overrun), 32'd0);
        tick();

        // 4: stray result during SEND sets sticky overrun, stream untouched
        drive(f4, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f4, -1, 0, 1, exp_max(9));
        chk("t4_ovr", 32'(bus.overrun), 32'd1);
        tick();
        chk("t4_ovr_sticky", 32'(bus.overrun), 32'd1);
        drive(f1, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f1, -1, 0, -1, exp_max(9));
        chk("t4_ovr_after", 32'(bus.overrun), 32'd1);
        tick();

        // 5: reset at beat 6 aborts the stream with no layer_done
        drive(f3, 10'h3FF);
        tick();
        bus.o_valid = '0;
        for (int b = 0; b < 6; b++) begin
            #1;
            chk("t5_pre_dat", 32'(bus.x_in), 32'(f3[b]));
            tick();
        end
        d0  = done_cnt;
        rst = 1'b0;
        #1;
        chk("t5_rst_vld", 32'(bus.x_valid), 32'd0);
        chk("t5_rst_done", 32'(bus.layer_done), 32'd0);
        chk("t5_rst_ovr", 32'(bus.overrun), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        #1;
        chk("t5_idle_vld", 32'(bus.x_valid), 32'd0);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        drive(f1, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f1, -1, 0, -1, 32'd0);
        tick();

        // 6: argmax with a tie, then an all-negative frame
        drive(f6, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f6, -1, 0, -1, exp_max(9));
        chk("t6_max_tie", 32'(bus.max_idx), exp_max(1));
        tick();
        drive(f7, 10'h3FF);
        tick();
        bus.o_valid = '0;
        expect_stream(f7, -1, 0, -1, exp_max(1));
        chk("t6_max_neg", 32'(bus.max_idx), exp_max(3));
        tick();
        chk("t6_max_held", 32'(bus.max_idx), exp_max(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
